divider_1: RTL and testbench

DIVIDER_1 -- requirements
Module: divider_1

---
 rtl/divider_pkg.sv | 59 +++++
 rtl/divider_step.sv | 28 ++
 rtl/divider_1.sv | 133 +++++++++++++
 tb/tb_divider_1.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types, constants and sign/saturation helpers for the fixed-point divider.
// Inverts a multiply by a 2^32-scaled fraction: quotient = in * 2^32 / constant.
package divider_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   localparam logic [WIDTH-1:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [WIDTH-1:0] SAT_NEG = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic             sat;
   } result_t;

   // Unsigned magnitude; the most negative value maps to 2^31.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] m;
      if (x[WIDTH-1]) begin
         m = ~x + 32'd1;
      end else begin
         m = x;
      end
      return m;
   endfunction

   // Applies the result sign to an unsigned quotient and clamps to the signed range.
   function automatic result_t apply_sign(input logic [WIDTH-1:0] q, input logic neg);
      result_t r;
      if (!neg) begin
         if (q > SAT_POS) begin
            r.value = SAT_POS;
            r.sat   = 1'b1;
         end else begin
            r.value = q;
            r.sat   = 1'b0;
         end
      end else begin
         if (q > SAT_NEG) begin
            r.value = SAT_NEG;
            r.sat   = 1'b1;
         end else if (q == SAT_NEG) begin
            r.value = SAT_NEG;
            r.sat   = 1'b0;
         end else begin
            r.value = ~q + 32'd1;
            r.sat   = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division step: shift the remainder left, compare against the
// divisor, subtract when it fits and report the resulting quotient bit.
module divider_step
   import divider_pkg::*;
(
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] divisor_s;

   // Shift/compare/subtract; a set top bit means the shifted value exceeds any divisor
   always_comb begin
      shifted_s = {rem_in[WIDTH-1:0], 1'b0};
      divisor_s = {1'b0, divisor};
      if (rem_in[WIDTH] || (shifted_s >= divisor_s)) begin
         rem_out = shifted_s - divisor_s;
         q_bit   = 1'b1;
      end else begin
         rem_out = shifted_s;
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/divider_1.sv
// Sequential signed fixed-point divider: out = trunc(in * 2^32 / constant),
// with divide-by-zero and saturation shortcuts and a valid/ready handshake.
module divider_1
   import divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] constant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             div_by_zero,
   output logic             saturated
);

   state_t           state_r;
   logic [WIDTH-1:0] mag_c_r;
   logic             sign_r;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-2:0] quo_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] out_r;
   logic             out_valid_r;
   logic             dbz_r;
   logic             sat_r;

   logic [WIDTH-1:0] mag_in_s;
   logic [WIDTH-1:0] mag_c_s;
   logic             sign_s;
   logic [WIDTH:0]   rem_next_s;
   logic             q_bit_s;
   logic [WIDTH-1:0] quo_next_s;
   result_t          fin_s;

   divider_step u_step (
      .rem_in  (rem_r),
      .divisor (mag_c_r),
      .rem_out (rem_next_s),
      .q_bit   (q_bit_s)
   );

   // Operand magnitudes, result sign and the signed result of the final step
   always_comb begin
      mag_in_s   = magnitude(in);
      mag_c_s    = magnitude(constant);
      sign_s     = in[WIDTH-1] ^ constant[WIDTH-1];
      quo_next_s = {quo_r, q_bit_s};
      fin_s      = apply_sign(quo_next_s, sign_r);
   end

   // Control FSM with registered datapath and outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         mag_c_r     <= '0;
         sign_r      <= 1'b0;
         rem_r       <= '0;
         quo_r       <= '0;
         cnt_r       <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         dbz_r       <= 1'b0;
         sat_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  mag_c_r <= mag_c_s;
                  sign_r  <= sign_s;
                  rem_r   <= {1'b0, mag_in_s};
                  quo_r   <= '0;
                  cnt_r   <= '0;
                  if (constant == 32'd0) begin
                     state_r     <= DONE;
                     out_r       <= in[WIDTH-1] ? SAT_NEG : SAT_POS;
                     out_valid_r <= 1'b1;
                     dbz_r       <= 1'b1;
                     sat_r       <= 1'b0;
                  end else if (mag_in_s >= mag_c_s) begin
                     // Quotient magnitude is at least 2^32: clamp without iterating
                     state_r     <= DONE;
                     out_r       <= sign_s ? SAT_NEG : SAT_POS;
                     out_valid_r <= 1'b1;
                     dbz_r       <= 1'b0;
                     sat_r       <= 1'b1;
                  end else begin
                     state_r <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               rem_r <= rem_next_s;
               quo_r <= quo_next_s[WIDTH-2:0];
               cnt_r <= cnt_r + 6'd1;
               if (cnt_r == 6'd31) begin
                  state_r     <= DONE;
                  out_r       <= fin_s.value;
                  out_valid_r <= 1'b1;
                  dbz_r       <= 1'b0;
                  sat_r       <= fin_s.sat;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  dbz_r       <= 1'b0;
                  sat_r       <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               dbz_r       <= 1'b0;
               sat_r       <= 1'b0;
            end
         endcase
      end
   end

   // Ready is masked by reset so it reads low while reset is held
   assign in_ready    = (state_r == IDLE) && !reset;
   assign out_valid   = out_valid_r;
   assign out         = out_r;
   assign div_by_zero = dbz_r;
   assign saturated   = sat_r;

endmodule

// File: tb/tb_divider_1.sv
// Randomised bench for divider_1 with a 64-bit arithmetic reference model.
module tb_divider_1;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_v;
   logic [31:0] const_v;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_v;
   logic        div_by_zero;
   logic        saturated;

   int          n_cmp;
   int          n_fail;
   int          cyc;
   int          acc_cyc;
   bit          pending;
   bit          seen;
   bit          mon_en;
   logic [31:0] exp_out;
   logic        exp_z;
   logic        exp_s;
   int          exp_lat;
   logic [31:0] r_a;
   logic [31:0] r_c;

   divider_1 #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in          (in_v),
      .constant    (const_v),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out         (out_v),
      .div_by_zero (div_by_zero),
      .saturated   (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: exact quotient in 64-bit arithmetic, then sign and clamp rules
   function automatic void model(input logic [31:0] a, input logic [31:0] c,
                                 output logic [31:0] o, output logic z,
                                 output logic s, output int lat);
      longint unsigned ma, mc, q;
      logic neg;
      if (c == 32'd0) begin
         o = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         z = 1'b1;
         s = 1'b0;
         lat = 1;
         return;
      end
      ma  = a[31] ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
      mc  = c[31] ? (64'd4294967296 - {32'd0, c}) : {32'd0, c};
      q   = (ma << 32) / mc;
      lat = (q >= 64'h1_0000_0000) ? 1 : 33;
      neg = a[31] ^ c[31];
      z   = 1'b0;
      if (!neg) begin
         if (q > 64'h7FFF_FFFF) begin o = 32'h7FFF_FFFF; s = 1'b1; end
         else begin o = q[31:0]; s = 1'b0; end
      end else begin
         if (q > 64'h8000_0000) begin o = 32'h8000_0000; s = 1'b1; end
         else begin o = 32'(64'd0 - q); s = 1'b0; end
      end
   endfunction

   task automatic pin(input logic [31:0] a, input logic [31:0] c, input logic [31:0] eo,
                      input logic ez, input logic es, input int el);
      logic [31:0] o;
      logic z, s;
      int l;
      model(a, c, o, z, s, l);
      chk("model_pin", {o, z, s, 8'(l)}, {eo, ez, es, 8'(el)});
   endtask

   // Every negedge: result/flags against the model while a transaction is open, idle flags otherwise
   always @(negedge clk) begin
      if (mon_en) begin
         if (pending) begin
            if (out_valid === 1'b1) begin
               chk("result", {out_v, div_by_zero, saturated}, {exp_out, exp_z, exp_s});
               if (!seen) begin
                  chk("latency", 64'(cyc - acc_cyc + 1), 64'(exp_lat));
                  seen = 1'b1;
               end
            end else if (seen) begin
               chk("valid_hold", {63'd0, out_valid}, 64'd1);
            end else begin
               chk("busy_flags", {div_by_zero, saturated}, 2'b00);
            end
         end else begin
            chk("idle_flags", {out_valid, div_by_zero, saturated}, 3'b000);
         end
      end
   end

   task automatic run(input logic [31:0] a, input logic [31:0] c, input int hold);
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      model(a, c, exp_out, exp_z, exp_s, exp_lat);
      in_valid = 1'b1;
      in_v     = a;
      const_v  = c;
      acc_cyc  = cyc + 1;
      seen     = 1'b0;
      pending  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_v     = $urandom;
      const_v  = $urandom;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_reached", {63'd0, out_valid}, 64'd1);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      pending   = 1'b0;
      chk("in_ready_after", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0; acc_cyc = 0;
      pending = 1'b0; seen = 1'b0; mon_en = 1'b0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_v = 32'd0; const_v = 32'd0;

      pin(32'h0000_0001, 32'd4, 32'h4000_0000, 1'b0, 1'b0, 33);
      pin(32'hFFFF_FFFF, 32'd4, 32'hC000_0000, 1'b0, 1'b0, 33);
      pin(32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 1'b0, 1'b0, 33);
      pin(32'h0000_0001, 32'd2, 32'h7FFF_FFFF, 1'b0, 1'b1, 33);
      pin(32'h0000_0005, 32'd3, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      pin(32'h0000_0005, 32'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
      pin(32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1, 1'b0, 1);
      pin(32'h0000_0003, 32'd7, 32'h6DB6_DB6D, 1'b0, 1'b0, 33);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {in_ready, out_valid, div_by_zero, saturated, out_v}, {4'b0000, 32'd0});
      reset = 1'b0;
      #1;
      chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
      mon_en = 1'b1;

      run(32'h0000_0001, 32'd4, 0);
      run(32'hFFFF_FFFF, 32'd4, 0);
      run(32'hFFFF_FFFF, 32'd2, 0);
      run(32'h0000_0001, 32'd2, 0);
      run(32'h0000_0005, 32'd3, 0);
      run(32'h0000_0005, 32'd0, 0);
      run(32'h8000_0000, 32'd0, 0);
      run(32'h0000_0003, 32'd7, 5);

      // Abandon a division partway through with reset
      @(negedge clk);
      model(32'd1, 32'd9, exp_out, exp_z, exp_s, exp_lat);
      in_valid = 1'b1; in_v = 32'd1; const_v = 32'd9;
      acc_cyc = cyc + 1; seen = 1'b0; pending = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      pending = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_reset", {in_ready, out_valid, div_by_zero, saturated, out_v}, {4'b0000, 32'd0});
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ready_after_mid_reset", {63'd0, in_ready}, 64'd1);
      run(32'h0000_0001, 32'd4, 0);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0: begin r_a = $urandom; r_c = $urandom; end
            1: begin
               r_c = $urandom;
               r_a = $urandom >> $urandom_range(1, 31);
               if ($urandom_range(0, 1) == 1) r_a = 32'd0 - r_a;
            end
            2: begin
               r_c = $urandom >> $urandom_range(0, 28);
               r_a = $urandom >> $urandom_range(4, 31);
               if ($urandom_range(0, 1) == 1) r_c = 32'd0 - r_c;
            end
            3: begin r_a = $urandom; r_c = 32'd0; end
            default: begin r_a = 32'h8000_0000; r_c = $urandom; end
         endcase
         run(r_a, r_c, $urandom_range(0, 3));
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
